evt_burst_gen: RTL and testbench

Programmable event-burst generator: on a start request it emits a fixed number of single-cycle event pulses at a fixed spacing, then reports completion. It is the producing end of the event interface that `evt_counter` consumes; its `evt_out` drives an `evt_in` directly, for baud ticks, timer stimulus and bench traffic. Start/busy/done handshake toward a controlling FSM or CPU-side register block.

---
 rtl/evt_pkg.sv | 16 +
 rtl/evt_gap_timer.sv | 27 ++
 rtl/evt_burst_gen.sv | 119 +++++++++++
 tb/tb_evt_burst_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkg.sv
// Shared event-interface package: burst FSM state encoding and width helpers.
// Imported by evt_burst_gen and the downstream evt_counter.
package evt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } evt_burst_state_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int evt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/evt_gap_timer.sv
// Loadable down-counter spacing burst events; saturates at zero, zero_out decodes the register.
// Load takes priority over decrement; no backpressure.
module evt_gap_timer #(
  parameter int PW = 9
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load_in,
  input  logic [PW-1:0] load_val_in,
  output logic          zero_out
);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_cnt <= '0;
    end else if (load_in) begin
      r_cnt <= load_val_in;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - PW'(1);
    end
  end

  assign zero_out = (r_cnt == '0);

endmodule

// File: rtl/evt_burst_gen.sv
// Burst generator: on accepted start emits N registered event pulses P cycles apart, then a one-cycle done.
// First event one cycle after acceptance; start ignored while busy. EVT_BURST_ABORT_EN adds abort_in/aborted_out.
module evt_burst_gen
  import evt_pkg::*;
#(
  parameter int   MAX_COUNT  = 115_200,
  parameter int   MAX_PERIOD = 256,
  localparam int  CW         = evt_width(MAX_COUNT),
  localparam int  PW         = evt_width(MAX_PERIOD)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [CW-1:0] count_in,
  input  logic [PW-1:0] period_in,
`ifdef EVT_BURST_ABORT_EN
  input  logic          abort_in,
  output logic          aborted_out,
`endif
  output logic          evt_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [CW-1:0] remaining_out
);

  evt_burst_state_t r_state;
  logic             r_evt;
  logic [CW-1:0]    r_rem;
  logic [PW-1:0]    r_period;

  logic             w_accept;
  logic             w_abort;
  logic             w_fire;
  logic             w_gap_zero;
  logic             w_gap_load;
  logic [PW-1:0]    w_gap_val;
  logic [CW-1:0]    w_n;
  logic [PW-1:0]    w_p;
  logic [CW-1:0]    w_rem_eff;

  assign w_accept = start_in && (r_state != RUN);

  always_comb begin
    w_n = count_in;
    if (count_in > CW'(MAX_COUNT)) w_n = CW'(MAX_COUNT);
    w_p = period_in;
    if (period_in == '0)                  w_p = PW'(1);
    else if (period_in > PW'(MAX_PERIOD)) w_p = PW'(MAX_PERIOD);
  end

`ifdef EVT_BURST_ABORT_EN
  assign w_abort = abort_in && (r_state == RUN);
`else
  assign w_abort = 1'b0;
`endif

  // remaining_out lags evt_out by one cycle; this is the count once the visible pulse is retired.
  assign w_rem_eff  = r_rem - CW'(r_evt);
  assign w_fire     = (r_state == RUN) && !w_abort && w_gap_zero && (w_rem_eff != '0);
  assign w_gap_load = w_accept || w_fire;
  assign w_gap_val  = w_accept ? (w_p - PW'(1)) : (r_period - PW'(1));

  evt_gap_timer #(.PW(PW)) u_gap (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (w_gap_load),
    .load_val_in (w_gap_val),
    .zero_out    (w_gap_zero)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state  <= IDLE;
      r_evt    <= 1'b0;
      r_rem    <= '0;
      r_period <= '0;
    end else begin
      r_evt <= 1'b0;
      case (r_state)
        RUN: begin
          r_rem <= w_rem_eff;
          if (w_abort || (w_rem_eff == '0)) r_state <= DONE;
          else if (w_fire)                  r_evt   <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_rem    <= w_n;
            r_period <= w_p;
            if (w_n == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= RUN;
              r_evt   <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef EVT_BURST_ABORT_EN
  logic r_aborted;

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_aborted <= 1'b0;
    else         r_aborted <= w_abort;
  end

  assign aborted_out = r_aborted;
`endif

  assign evt_out       = r_evt;
  assign busy_out      = (r_state == RUN);
  assign done_out      = (r_state == DONE);
  assign remaining_out = r_rem;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Scoreboard bench for evt_burst_gen: expected events/done pushed at start, popped by a negedge monitor.
// Abort scenarios build only with EVT_BURST_ABORT_EN.
module tb_evt_burst_gen;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [16:0] count_in;
  logic [8:0]  period_in;
  logic        evt_out;
  logic        busy_out;
  logic        done_out;
  logic [16:0] remaining_out;
`ifdef EVT_BURST_ABORT_EN
  logic        abort_in;
  logic        aborted_out;
`endif

  evt_burst_gen dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .count_in      (count_in),
    .period_in     (period_in),
`ifdef EVT_BURST_ABORT_EN
    .abort_in      (abort_in),
    .aborted_out   (aborted_out),
`endif
    .evt_out       (evt_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .remaining_out (remaining_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int   cyc;
    int   rem;
    logic ab;
  } exp_t;

  exp_t evt_q[$];
  exp_t done_q[$];
  int   cyc     = 0;
  int   vec     = 0;
  int   errs    = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  logic mon_en  = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // Expected response of a normal (unaborted, unreset) burst accepted at cycle t0.
  task automatic exp_burst(input int t0, input int n, input int p);
    int pe;
    exp_t e;
    pe = (p == 0) ? 1 : ((p > 256) ? 256 : p);
    if (n == 0) begin
      e = '{t0 + 1, 0, 1'b0};
      done_q.push_back(e);
    end else begin
      for (int k = 1; k <= n; k++) begin
        e = '{t0 + 1 + (k - 1) * pe, n - k + 1, 1'b0};
        evt_q.push_back(e);
      end
      e = '{t0 + 2 + (n - 1) * pe, 0, 1'b0};
      done_q.push_back(e);
      busy_lo = t0 + 1;
      busy_hi = t0 + 1 + (n - 1) * pe;
    end
  endtask

  // Called just after a posedge; start is high for the current cycle only.
  task automatic go(input int n, input int p);
    start_in  = 1'b1;
    count_in  = 17'(n);
    period_in = 9'(p);
    exp_burst(cyc, n, p);
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((evt_q.size() != 0 || done_q.size() != 0) && n < 400) begin
      @(posedge clk_in);
      n++;
    end
    vec++;
    if (n >= 400) begin
      errs++;
      $display("FAIL drain_timeout cyc=%0d evt_left=%0d done_left=%0d exp=0", cyc, evt_q.size(), done_q.size());
    end
    @(posedge clk_in); #1;
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (mon_en) begin
      vec++;
      if (busy_out !== ((cyc >= busy_lo) && (cyc <= busy_hi))) begin
        errs++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_out, ((cyc >= busy_lo) && (cyc <= busy_hi)));
      end
      if (evt_out === 1'b1) begin
        vec++;
        if (evt_q.size() == 0) begin
          errs++;
          $display("FAIL evt_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          e = evt_q.pop_front();
          if (e.cyc != cyc || e.rem != int'(remaining_out)) begin
            errs++;
            $display("FAIL evt cyc=%0d rem=%0d exp_cyc=%0d exp_rem=%0d", cyc, remaining_out, e.cyc, e.rem);
          end
        end
      end
      if (done_out === 1'b1) begin
        vec++;
        if (done_q.size() == 0) begin
          errs++;
          $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          e = done_q.pop_front();
          if (e.cyc != cyc || e.rem != int'(remaining_out)
`ifdef EVT_BURST_ABORT_EN
              || aborted_out !== e.ab
`endif
             ) begin
            errs++;
            $display("FAIL done cyc=%0d rem=%0d exp_cyc=%0d exp_rem=%0d exp_ab=%b", cyc, remaining_out, e.cyc, e.rem, e.ab);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    exp_t e;
    rst_in    = 1'b0;
    start_in  = 1'b0;
    count_in  = '0;
    period_in = '0;
`ifdef EVT_BURST_ABORT_EN
    abort_in  = 1'b0;
`endif
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_evt", int'(evt_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_rem", int'(remaining_out), 0);
`ifdef EVT_BURST_ABORT_EN
    chk("rst_aborted", int'(aborted_out), 0);
`endif
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_in); #1;

    go(3, 4);   wait_idle();
    go(4, 1);   wait_idle();
    go(0, 5);   wait_idle();
    go(2, 0);   wait_idle();
    go(2, 300); wait_idle();

    // start while busy must be ignored
    t0 = cyc;
    go(2, 3);
    @(posedge clk_in); #1;
    start_in = 1'b1; count_in = 17'd7; period_in = 9'd1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_idle();

    // start held through DONE chains straight into the next burst
    go(1, 5);
    start_in = 1'b1; count_in = 17'd2; period_in = 9'd2;
    @(posedge clk_in); #1;
    exp_burst(cyc, 2, 2);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_idle();

    // reset during a burst discards it
    t0 = cyc;
    start_in = 1'b1; count_in = 17'd5; period_in = 9'd3;
    e = '{t0 + 1, 5, 1'b0}; evt_q.push_back(e);
    e = '{t0 + 4, 4, 1'b0}; evt_q.push_back(e);
    busy_lo = t0 + 1; busy_hi = t0 + 6;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (5) begin @(posedge clk_in); #1; end
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    start_in = 1'b1; count_in = 17'd1; period_in = 9'd1;
    @(negedge clk_in);
    chk("postrst_evt", int'(evt_out), 0);
    chk("postrst_busy", int'(busy_out), 0);
    chk("postrst_done", int'(done_out), 0);
    chk("postrst_rem", int'(remaining_out), 0);
    exp_burst(cyc, 1, 1);
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_idle();

`ifdef EVT_BURST_ABORT_EN
    t0 = cyc;
    start_in = 1'b1; count_in = 17'd5; period_in = 9'd2;
    e = '{t0 + 1, 5, 1'b0}; evt_q.push_back(e);
    e = '{t0 + 3, 4, 1'b0}; evt_q.push_back(e);
    e = '{t0 + 5, 3, 1'b1}; done_q.push_back(e);
    busy_lo = t0 + 1; busy_hi = t0 + 4;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    abort_in = 1'b1;
    @(posedge clk_in); #1;
    abort_in = 1'b0;
    wait_idle();
    abort_in = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; end
    abort_in = 1'b0;
    go(1, 1); wait_idle();
`endif

    repeat (5) begin @(posedge clk_in); #1; end
    chk("evt_q_empty", evt_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
